// File: rtl/hamming_best_match.sv
// Streaming nearest-neighbour selector: keeps the smallest and second-smallest
// Hamming distances of a search and emits one result beat with match decisions.
module hamming_best_match #(
  parameter int DIST_W = 8,
  parameter int IDX_W  = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DIST_W-1:0] i_thresh,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DIST_W-1:0] i_in_dist,
  input  logic              i_in_last,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [IDX_W-1:0]  o_out_idx,
  output logic [DIST_W-1:0] o_out_best,
  output logic [DIST_W-1:0] o_out_second,
  output logic              o_out_match,
  output logic              o_out_trunc
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} stateType;

  stateType          r_state;
  logic [DIST_W-1:0] r_thresh;
  logic [DIST_W-1:0] r_best;
  logic [DIST_W-1:0] r_second;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_cnt;

  logic [DIST_W-1:0] w_nextBest;
  logic [DIST_W-1:0] w_nextSecond;
  logic [IDX_W-1:0]  w_nextIdx;
  logic [DIST_W+1:0] w_best4;
  logic [DIST_W+1:0] w_second3;
  logic              w_match;
  logic              w_accept;
  logic              w_lastIdx;
  logic              w_close;

  // A start in SCAN restarts the search, so the beat offered alongside it is refused.
  assign o_in_ready = (r_state == SCAN) && !i_start;
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_lastIdx  = (r_cnt == {IDX_W{1'b1}});
  assign w_close    = w_accept && (i_in_last || w_lastIdx);

  always_comb begin
    w_nextBest   = r_best;
    w_nextSecond = r_second;
    w_nextIdx    = r_idx;
    if (i_in_dist < r_best) begin
      w_nextSecond = r_best;
      w_nextBest   = i_in_dist;
      w_nextIdx    = r_cnt;
    end else if (i_in_dist < r_second) begin
      w_nextSecond = i_in_dist;
    end
  end

  // Ratio test 4*best < 3*second, widened by two bits so neither product overflows.
  assign w_best4   = {w_nextBest, 2'b00};
  assign w_second3 = {2'b00, w_nextSecond} + {1'b0, w_nextSecond, 1'b0};
  assign w_match   = (w_nextBest <= r_thresh) && (w_best4 < w_second3);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_thresh     <= '0;
      r_best       <= '1;
      r_second     <= '1;
      r_idx        <= '0;
      r_cnt        <= '0;
      o_out_valid  <= 1'b0;
      o_out_idx    <= '0;
      o_out_best   <= '1;
      o_out_second <= '1;
      o_out_match  <= 1'b0;
      o_out_trunc  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, SCAN: begin
          if (i_start) begin
            r_state  <= SCAN;
            r_thresh <= i_thresh;
            r_best   <= '1;
            r_second <= '1;
            r_idx    <= '0;
            r_cnt    <= '0;
          end else if (w_accept) begin
            r_best   <= w_nextBest;
            r_second <= w_nextSecond;
            r_idx    <= w_nextIdx;
            // The counter holds at its top value; exhaustion closes the search instead.
            if (!w_close) begin
              r_cnt <= r_cnt + 1'b1;
            end
            if (w_close) begin
              r_state      <= DONE;
              o_out_valid  <= 1'b1;
              o_out_idx    <= w_nextIdx;
              o_out_best   <= w_nextBest;
              o_out_second <= w_nextSecond;
              o_out_match  <= w_match;
              o_out_trunc  <= !i_in_last;
            end
          end
        end
        DONE: begin
          if (i_out_ready) begin
            r_state     <= IDLE;
            o_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          o_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
